// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared constants for the 32 x 32-bit register file and its read-path muxes.
//   DATA_W    : register / data width (32)
//   ADDR_W    : register index width (5)
//   NUM_REGS  : architectural register count, including the hardwired r0
//   ZERO_REG  : index of the hardwired-zero register
//   NUM_RD    : number of read ports (rs, rt)
// -----------------------------------------------------------------------------
package register_file_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 2;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   // Write-through hit for one read port. r0 never bypasses, and the bypass
   // is masked during reset so that reads show the stored contents.
   function automatic logic bypass_hit(input logic              we,
                                       input logic              rst,
                                       input logic [ADDR_W-1:0] waddr,
                                       input logic [ADDR_W-1:0] raddr);
      return we && !rst && (waddr != ZERO_REG) && (waddr == raddr);
   endfunction

endpackage

// File: rtl/bit32_2to1mux.sv
// -----------------------------------------------------------------------------
// bit32_2to1mux
// 32-bit two-input multiplexer.
//   i_in0 : data selected when i_sel = 0
//   i_in1 : data selected when i_sel = 1
//   i_sel : select
//   o_out : selected data
// -----------------------------------------------------------------------------
module bit32_2to1mux
   import register_file_pkg::*;
(
   input  logic [DATA_W-1:0] i_in0,
   input  logic [DATA_W-1:0] i_in1,
   input  logic              i_sel,
   output logic [DATA_W-1:0] o_out
);

   assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/bit32_32to1mux.sv
// -----------------------------------------------------------------------------
// bit32_32to1mux
// 32-bit, 32-input multiplexer.
//   i_in  : 32 packed 32-bit inputs, i_in[k] is input k
//   i_sel : 5-bit select
//   o_out : i_in[i_sel]
// -----------------------------------------------------------------------------
module bit32_32to1mux
   import register_file_pkg::*;
(
   input  logic [NUM_REGS-1:0][DATA_W-1:0] i_in,
   input  logic [ADDR_W-1:0]               i_sel,
   output logic [DATA_W-1:0]               o_out
);

   assign o_out = i_in[i_sel];

endmodule

// File: rtl/register_file_rdport.sv
// -----------------------------------------------------------------------------
// register_file_rdport
// One combinational read port: a 32:1 select over the register array,
// followed by a write-through bypass so that a write-back in the same
// cycle is visible to decode immediately.
//   i_regs  : register array, entry 0 is the constant zero
//   i_raddr : read index
//   i_rst   : synchronous reset in progress (masks the bypass)
//   i_wen   : write enable
//   i_waddr : write index
//   i_wdata : write data
//   o_rdata : read data
// -----------------------------------------------------------------------------
module register_file_rdport
   import register_file_pkg::*;
(
   input  logic [NUM_REGS-1:0][DATA_W-1:0] i_regs,
   input  logic [ADDR_W-1:0]               i_raddr,
   input  logic                            i_rst,
   input  logic                            i_wen,
   input  logic [ADDR_W-1:0]               i_waddr,
   input  logic [DATA_W-1:0]               i_wdata,
   output logic [DATA_W-1:0]               o_rdata
);

   logic [DATA_W-1:0] w_stored;
   logic              w_byp;

   bit32_32to1mux u_sel (
      .i_in  (i_regs),
      .i_sel (i_raddr),
      .o_out (w_stored)
   );

   assign w_byp = bypass_hit(i_wen, i_rst, i_waddr, i_raddr);

   bit32_2to1mux u_byp (
      .i_in0 (w_stored),
      .i_in1 (i_wdata),
      .i_sel (w_byp),
      .o_out (o_rdata)
   );

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// MIPS-style 32 x 32-bit register file: one write port, two combinational
// read ports with write-through bypass, r0 hardwired to zero.
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset, clears r1..r31
//   regWrite  : write enable from write-back
//   writeReg  : destination index
//   writeData : write data
//   readReg1  : read port 1 index (rs)
//   readReg2  : read port 2 index (rt)
//   readData1 : read port 1 data
//   readData2 : read port 2 data
// -----------------------------------------------------------------------------
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] writeData,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2
);
   import register_file_pkg::NUM_REGS;
   import register_file_pkg::NUM_RD;

   logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
   logic [NUM_REGS-1:0]             w_wdec;
   logic [NUM_RD-1:0][ADDR_W-1:0]   w_raddr;
   logic [NUM_RD-1:0][DATA_W-1:0]   w_rdata;

   // r0 has no storage; it enters the read muxes as a constant.
   assign w_regs[0] = '0;
   assign w_wdec[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] r_q;

         // One-hot decode gated by regWrite.
         assign w_wdec[gi] = regWrite && (writeReg == ADDR_W'(gi));

         // Reset wins over a same-edge write; the write is simply lost.
         always_ff @(posedge clk) begin
            if (reset)
               r_q <= '0;
            else if (w_wdec[gi])
               r_q <= writeData;
         end

         assign w_regs[gi] = r_q;
      end
   endgenerate

   assign w_raddr[0] = readReg1;
   assign w_raddr[1] = readReg2;

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         register_file_rdport u_rd (
            .i_regs  (w_regs),
            .i_raddr (w_raddr[gi]),
            .i_rst   (reset),
            .i_wen   (regWrite),
            .i_waddr (writeReg),
            .i_wdata (writeData),
            .o_rdata (w_rdata[gi])
         );
      end
   endgenerate

   assign readData1 = w_rdata[0];
   assign readData2 = w_rdata[1];

endmodule
